// File: rtl/patp_pkg.sv
// patp_pkg: shared widths, arbiter state encoding and port identifiers for the store arbiter.
package patp_pkg;
    localparam int ADDR_W = 5;
    localparam int DATA_W = 8;
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} arb_state_t;
    typedef enum logic {PORT_F, PORT_D} port_id_t;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: combinational two-way round-robin picker; on a tie the port not granted last wins.
module rr_arb2
    import patp_pkg::*;
(
    input  logic [1:0] req,
    input  port_id_t   last_grant,
    output logic       gnt_valid,
    output port_id_t   gnt_id
);
    always_comb begin
        gnt_valid = |req;
        gnt_id    = (req == 2'b11) ? ((last_grant == PORT_F) ? PORT_D : PORT_F)
                  : (req[1] ? PORT_D : PORT_F);
    end
endmodule

// File: rtl/store_arbiter.sv
// store_arbiter: shares the single-port 32x8 main store between the fetch port and the data port,
// one IDLE/ACCESS/DONE sequence per access with round-robin arbitration.
module store_arbiter
    import patp_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    output logic              f_ack,
    output logic [DATA_W-1:0] f_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic              st_read,
    output logic              st_write,
    output logic [ADDR_W-1:0] st_address,
    output logic [DATA_W-1:0] st_wdata,
    input  logic [DATA_W-1:0] st_rdata,
    output logic              busy
);
    arb_state_t        r_state, w_next;
    port_id_t          r_last, r_owner, w_last, w_owner, w_gnt_id;
    logic              w_gnt_valid, w_grant, r_we, w_we;
    logic [ADDR_W-1:0] r_addr, w_addr;
    logic [DATA_W-1:0] r_wdata, w_wdata;
    logic              w_st_read, w_st_write, w_f_ack, w_d_ack, w_busy;
    logic [ADDR_W-1:0] w_st_address;
    logic [DATA_W-1:0] w_st_wdata;

    rr_arb2 u_arb (
        .req       ({d_req, f_req}),
        .last_grant(r_last),
        .gnt_valid (w_gnt_valid),
        .gnt_id    (w_gnt_id)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    // Requests are only looked at in IDLE, so a req still high during DONE cannot be granted twice.
    always_comb begin
        w_grant = (r_state == IDLE) && w_gnt_valid;
        w_next  = w_grant ? ACCESS : (r_state == ACCESS) ? DONE : IDLE;
        w_owner = w_grant ? w_gnt_id : r_owner;
        w_last  = w_grant ? w_gnt_id : r_last;
        w_addr  = w_grant ? ((w_gnt_id == PORT_F) ? f_addr : d_addr) : r_addr;
        w_wdata = w_grant ? ((w_gnt_id == PORT_D) ? d_wdata : '0) : r_wdata;
        w_we    = w_grant ? ((w_gnt_id == PORT_D) && d_we) : r_we;
    end

    always_comb begin
        w_st_read    = (w_next == ACCESS) && !w_we;
        w_st_write   = (w_next == ACCESS) && w_we;
        w_st_address = (w_next == ACCESS) ? w_addr : '0;
        w_st_wdata   = (w_next == ACCESS) ? w_wdata : '0;
        w_f_ack      = (w_next == DONE) && (w_owner == PORT_F);
        w_d_ack      = (w_next == DONE) && (w_owner == PORT_D);
        w_busy       = (w_next != IDLE);
    end

    // Reset clears st_write at once, so an aborted write never reaches a store edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last     <= PORT_D;
            r_owner    <= PORT_F;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_we       <= 1'b0;
            st_read    <= 1'b0;
            st_write   <= 1'b0;
            st_address <= '0;
            st_wdata   <= '0;
            f_ack      <= 1'b0;
            d_ack      <= 1'b0;
            busy       <= 1'b0;
        end else begin
            r_last     <= w_last;
            r_owner    <= w_owner;
            r_addr     <= w_addr;
            r_wdata    <= w_wdata;
            r_we       <= w_we;
            st_read    <= w_st_read;
            st_write   <= w_st_write;
            st_address <= w_st_address;
            st_wdata   <= w_st_wdata;
            f_ack      <= w_f_ack;
            d_ack      <= w_d_ack;
            busy       <= w_busy;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            f_rdata <= '0;
            d_rdata <= '0;
        end else if (r_state == ACCESS && !r_we) begin
            if (r_owner == PORT_F) f_rdata <= st_rdata;
            else                   d_rdata <= st_rdata;
        end
    end
endmodule

// File: tb/tb_store_arbiter.sv
// tb_store_arbiter: directed vector table plus reset-abort and saturation sequences for store_arbiter.
module tb_store_arbiter;
    import patp_pkg::*;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              f_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
    logic [ADDR_W-1:0] f_addr = '0, d_addr = '0;
    logic [DATA_W-1:0] d_wdata = '0;
    logic              f_ack, d_ack, st_read, st_write, busy;
    logic [DATA_W-1:0] f_rdata, d_rdata, st_wdata, st_rdata;
    logic [ADDR_W-1:0] st_address;
    logic              pre_we = 1'b0;
    logic [ADDR_W-1:0] pre_a = '0;
    logic [DATA_W-1:0] pre_d = '0;
    logic [DATA_W-1:0] mem [32];
    int checks = 0;
    int errors = 0;

    typedef struct {
        logic fr; logic [4:0] fa;
        logic dr; logic dwe; logic [4:0] da; logic [7:0] dwd;
        int efc; int edc; logic [7:0] efd; logic [7:0] edd;
    } vec_t;
    vec_t vecs[8];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (pre_we) mem[pre_a] <= pre_d;
        else if (st_write) mem[st_address] <= st_wdata;
    end
    assign st_rdata = mem[st_address];

    store_arbiter dut (
        .clk(clk), .rst(rst),
        .f_req(f_req), .f_addr(f_addr), .f_ack(f_ack), .f_rdata(f_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata),
        .st_read(st_read), .st_write(st_write), .st_address(st_address),
        .st_wdata(st_wdata), .st_rdata(st_rdata), .busy(busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_txn(input int idx, input vec_t v);
        int fc = 0, dc = 0, acc = 0, both = 0, extra = 0;
        bit done = 0;
        @(posedge clk); #1;
        f_req = v.fr; f_addr = v.fa;
        d_req = v.dr; d_we = v.dwe; d_addr = v.da; d_wdata = v.dwd;
        for (int cyc = 1; cyc <= 20 && !done; cyc++) begin
            @(negedge clk);
            if (f_ack && d_ack) both++;
            if (st_read && st_write) both++;
            if (st_read || st_write) acc++;
            if (f_ack) begin
                if (fc == 0) fc = cyc; else extra++;
                f_req = 1'b0;
            end
            if (d_ack) begin
                if (dc == 0) dc = cyc; else extra++;
                d_req = 1'b0;
            end
            done = (!v.fr || fc != 0) && (!v.dr || dc != 0);
        end
        repeat (3) begin
            @(negedge clk);
            if (f_ack || d_ack) extra++;
        end
        chk($sformatf("v%0d f_ack_cycle", idx), fc, v.efc);
        chk($sformatf("v%0d d_ack_cycle", idx), dc, v.edc);
        chk($sformatf("v%0d f_rdata", idx), f_rdata, v.efd);
        chk($sformatf("v%0d d_rdata", idx), d_rdata, v.edd);
        chk($sformatf("v%0d store_accesses", idx), acc, int'(v.fr) + int'(v.dr));
        chk($sformatf("v%0d overlap", idx), both, 0);
        chk($sformatf("v%0d extra_acks", idx), extra, 0);
        chk($sformatf("v%0d busy_idle", idx), busy, 0);
    endtask

    initial begin
        int seq_cyc[8];
        int seq_port[8];
        int n = 0, fn = 0, dn = 0, both = 0, bad = 0;
        //            fr  fa  dr dwe da  dwd    efc edc efd    edd
        vecs[0] = '{1, 3,  0, 0, 0,  8'h00, 3, 0, 8'hA5, 8'h00};
        vecs[1] = '{0, 0,  1, 1, 10, 8'h3C, 0, 3, 8'hA5, 8'h00};
        vecs[2] = '{0, 0,  1, 0, 10, 8'h00, 0, 3, 8'hA5, 8'h3C};
        vecs[3] = '{1, 10, 1, 1, 20, 8'h77, 3, 6, 8'h3C, 8'h3C};
        vecs[4] = '{1, 20, 1, 0, 3,  8'h00, 3, 6, 8'h77, 8'hA5};
        vecs[5] = '{1, 0,  0, 0, 0,  8'h00, 3, 0, 8'h00, 8'hA5};
        vecs[6] = '{1, 3,  1, 0, 20, 8'h00, 6, 3, 8'hA5, 8'h77};
        vecs[7] = '{1, 0,  1, 1, 0,  8'h99, 6, 3, 8'h99, 8'h77};

        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            pre_we = 1'b1; pre_a = 5'(i); pre_d = (i == 3) ? 8'hA5 : 8'h00;
        end
        @(negedge clk); pre_we = 1'b0;
        @(negedge clk);
        chk("reset st_ctl", {st_read, st_write, busy, f_ack, d_ack}, 0);
        chk("reset st_bus", {st_address, st_wdata}, 0);
        chk("reset rdata", {f_rdata, d_rdata}, 0);
        @(posedge clk); #1 rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            run_txn(i, vecs[i]);
            if (i == 1) chk("store[10] written", mem[10], 8'h3C);
        end
        chk("store[0] written", mem[0], 8'h99);

        // Reset while a data write to address 7 sits in ACCESS.
        @(posedge clk); #1;
        d_req = 1'b1; d_we = 1'b1; d_addr = 5'd7; d_wdata = 8'h55;
        @(posedge clk); #1;
        chk("abort pre write", {st_write, st_address}, {1'b1, 5'd7});
        rst = 1'b1; d_req = 1'b0;
        #1;
        chk("abort st outputs", {st_read, st_write, st_address, st_wdata, busy}, 0);
        f_req = 1'b1; f_addr = 5'd3; d_req = 1'b1; d_we = 1'b0; d_addr = 5'd10;
        repeat (3) begin
            @(negedge clk);
            if (f_ack || d_ack || busy || st_read || st_write) bad++;
        end
        chk("held in reset", bad, 0);
        chk("store[7] unchanged", mem[7], 8'h00);

        // Both ports saturated from the first edge after reset release.
        @(posedge clk); #1 rst = 1'b0;
        for (int cyc = 1; cyc <= 40 && n < 8; cyc++) begin
            @(negedge clk);
            if (f_ack && d_ack) both++;
            if (f_ack) begin
                seq_cyc[n] = cyc; seq_port[n] = 0; n++; fn++;
                if (fn == 4) f_req = 1'b0;
            end
            if (d_ack && n < 8) begin
                seq_cyc[n] = cyc; seq_port[n] = 1; n++; dn++;
                if (dn == 4) d_req = 1'b0;
            end
        end
        chk("sat ack_count", n, 8);
        chk("sat overlap", both, 0);
        for (int k = 0; k < n; k++) begin
            chk($sformatf("sat ack%0d port", k), seq_port[k], k % 2);
            chk($sformatf("sat ack%0d cycle", k), seq_cyc[k], 3 * (k + 1));
        end
        bad = 0;
        repeat (4) begin
            @(negedge clk);
            if (f_ack || d_ack) bad++;
        end
        chk("sat no_regrant", bad, 0);
        chk("sat f_rdata", f_rdata, 8'hA5);
        chk("sat d_rdata", d_rdata, 8'h3C);
        chk("store[7] still 0", mem[7], 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
